// File: rtl/moore_pkg.sv
// Shared types for the Moore event counter family.
// State encoding and counting-mode constants.
package moore_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    ARMED = 2'b01,
    HELD  = 2'b10
  } state_t;

  localparam int LEVEL = 0;
  localparam int EDGE  = 1;

endpackage

// File: rtl/phase_counter.sv
// Modulo-MOD phase register with a registered wrap pulse.
// Clear has priority over increment.
module phase_counter #(
  parameter int MOD = 3,
  parameter int PW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] phase,
  output logic          wrap
);

  logic [PW-1:0] r_phase;
  logic          r_wrap;
  logic          w_last;

  assign w_last = (r_phase == PW'(MOD - 1));
  assign phase  = r_phase;
  assign wrap   = r_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (inc) begin
      r_phase <= w_last ? '0 : r_phase + PW'(1);
      r_wrap  <= w_last;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

endmodule

// File: rtl/moore_mod_counter.sv
// Parametrised Moore event counter: phase modulo MOD, wrap pulse,
// event total with sticky overflow, level or edge qualified events.
module moore_mod_counter
  import moore_pkg::*;
#(
  parameter int MOD       = 3,
  parameter int PW        = $clog2(MOD),
  parameter int CW        = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          in,
  output logic          out,
  output logic [PW-1:0] phase,
  output logic          tc,
  output logic [CW-1:0] count,
  output logic          ovf
);

  if (MOD < 2 || MOD > 256) begin : g_mod_chk
    $fatal(1, "moore_mod_counter: MOD must be within 2..256");
  end

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_out;
  logic          w_acc;
  logic          w_last;
  logic [PW-1:0] w_phase;

  assign w_acc  = (r_state == ARMED) && en && in && !clr;
  assign w_last = (w_phase == PW'(MOD - 1));

  phase_counter #(
    .MOD (MOD),
    .PW  (PW)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (w_acc),
    .phase (w_phase),
    .wrap  (tc)
  );

  // out decodes the next phase so it moves on the same edge as phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_out   <= 1'b1;
    end else begin
      unique case (r_state)
        INIT:    r_state <= (EDGE_MODE == EDGE && in) ? HELD : ARMED;
        ARMED:   if (EDGE_MODE == EDGE && w_acc) r_state <= HELD;
        HELD:    if (!in && !clr) r_state <= ARMED;
        default: r_state <= INIT;
      endcase
      if (clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_out   <= 1'b1;
      end else if (w_acc) begin
        r_count <= r_count + CW'(1);
        r_out   <= w_last;
        if (&r_count) r_ovf <= 1'b1;
      end
    end
  end

  assign out   = r_out;
  assign phase = w_phase;
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: doc/moore_mod_counter.md
# moore_mod_counter

Parametrised Moore event counter, successor to the fixed three-state counter in the FSM exercises. Counts qualified events on `in` modulo `MOD` and drives `out` high whenever the phase is 0. It also provides the current phase, a wrap pulse, a free-running event total with a sticky overflow flag, and a selectable level/edge counting mode. Sits stand-alone in the FSM examples and is the template for later counter-style Moore machines.

## Interface
- `MOD`, 3, modulus; legal range 2..256; phase counts 0..MOD-1
- `PW`, $clog2(MOD), phase width (derived, do not override)
- `CW`, 8, width of event total `count`
- `EDGE_MODE`, 0, 0 = every sampled-high cycle is an event; 1 = only a 0→1 transition of `in` is an event
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  event qualifier; events ignored while low
- `clr`  in  1  synchronous clear of phase/count/ovf (keeps FSM running)
- `in`  in  1  event input, synchronous to `clk`
- `out`  out  1  Moore output: 1 iff phase == 0
- `phase`  out  PW  current phase
- `tc`  out  1  one-cycle pulse when phase wraps MOD-1 → 0
- `count`  out  CW  total accepted events, wraps at 2^CW
- `ovf`  out  1  sticky, set when `count` wraps

## Operation
- Control FSM states: INIT, ARMED, HELD.
  - INIT: entered on reset and lasts exactly one cycle; no events are accepted. Exits to HELD if EDGE_MODE=1 and `in`=1, otherwise to ARMED.
  - ARMED: an event is accepted when `en`=1 and `in`=1. In EDGE_MODE=1, an accepted event moves the FSM to HELD. In EDGE_MODE=0, the FSM stays in ARMED.
  - HELD (EDGE_MODE=1 only): no events. Returns to ARMED on the cycle `in`=0 is sampled, regardless of `en`. A rising edge while `en`=0 is therefore lost.
- Accepted event: phase ← (phase==MOD-1) ? 0 : phase+1; count ← count+1 mod 2^CW; tc ← 1 iff phase was MOD-1; ovf ← 1 if count was all-ones.
- `out` is a registered decode of the next phase, so `out`, `phase` and `tc` change on the same edge.
- Priority: `rst` > `clr` > event.
  - `clr`: phase=0, count=0, ovf=0, tc=0, out=1. An event in the same cycle is dropped. FSM state is unchanged.
- Reset values: out=1, phase=0, tc=0, count=0, ovf=0, FSM=INIT.
- Reset mid-count restarts from INIT on the next edge. No partial state survives.
- No event in a cycle: tc=0, all other outputs hold.

## Timing
- `in` sampled at posedge k → phase/out/tc/count/ovf updated at that same edge (visible after edge k). Latency 1 cycle; no combinational path from inputs to outputs.
- EDGE_MODE=0: continuous high `in` with `en`=1 counts every cycle. `out` is high once every MOD cycles.
- EDGE_MODE=1: minimum event spacing is 2 cycles (high, low).
- `tc` is never high for two consecutive cycles, since MOD≥2.
- First event can be accepted at the second posedge after `rst` deasserts (INIT consumes one cycle).

## Structure
- Package `moore_pkg`: state typedef (INIT=2'b00, ARMED=2'b01, HELD=2'b10) and mode constants LEVEL=0, EDGE=1.
- Sub-module `phase_counter` (params MOD, PW; ports clk, rst, clr, inc → phase, wrap). Top holds the FSM, `count`/`ovf` and `out` decode.
- Elaboration-time check: MOD outside 2..256 is a fatal error.

## Test plan
- Reset: MOD=3, hold rst 2 cycles with in=1 → out=1, phase=0, count=0, tc=0, ovf=0. No event counted on the first cycle after release (INIT).
- Level mode: MOD=3, en=1, in=1 for 7 cycles after INIT → phase 1,2,0,1,2,0,1; out 0,0,1,0,0,1,0; tc pulses on cycles 3 and 6; count=7.
- Edge mode: MOD=4, in toggles 1,1,1,0,1,0,1 → 3 events. A 3-cycle high counts once; phase=3, out=0. `in` high during INIT does not count.
- Qualifiers: en=0 during one rising edge in edge mode → edge lost, phase unchanged. clr and event in the same cycle → phase=0, count=0, out=1, tc=0.
- Overflow: CW=4, MOD=5, 16 level events → count wraps to 0, ovf=1 and stays set. Phase=1 (16 mod 5).
- Reset mid-operation: MOD=3, phase=2, assert rst for one cycle during in=1 → all outputs at reset values, FSM INIT, next count resumes from phase 0.
